// File: rtl/apu_uart_pkg.sv
// Shared types and byte encoding for the APU register-write UART link.
package apu_uart_pkg;

  localparam int   CLKS_PER_BIT_DEFAULT = 1250;
  localparam logic START_BIT            = 1'b0;
  localparam logic STOP_BIT             = 1'b1;
  localparam logic ADDR_FLAG            = 1'b1;

  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} tx_state_t;

  typedef struct packed {
    logic [5:0] index;
    logic [7:0] data;
  } apu_wr_t;

  // The data MSB travels in the LSB of the address byte so both bytes fit 7+1 bits.
  function automatic logic [7:0] enc_data_byte(apu_wr_t w);
    return {1'b0, w.data[6:0]};
  endfunction

  function automatic logic [7:0] enc_addr_byte(apu_wr_t w);
    return {ADDR_FLAG, w.index, w.data[7]};
  endfunction

endpackage

// File: rtl/apu_reg_uart_tx_if.sv
// Register-write request channel: valid/ready handshake carrying index and data.
interface apu_reg_uart_tx_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [5:0] wr_index;
  logic [7:0] wr_data;

  modport master (output wr_valid, output wr_index, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_index, input wr_data, output wr_ready);
endinterface

// File: rtl/apu_reg_uart_tx_byte.sv
// Single-byte 8N1 serializer with baud counter; tx is registered one clock behind the FSM.
module uart_tx_byte
  import apu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic [7:0] byte_i,
  output logic       idle_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [1:0]    ST_IDLE  = 2'(IDLE);
  localparam logic [1:0]    ST_START = 2'(START);
  localparam logic [1:0]    ST_DATA  = 2'(DATA);
  localparam logic [1:0]    ST_STOP  = 2'(STOP);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_LAST);
  assign idle_o  = (state_q == ST_IDLE);
  assign done_o  = (state_q == ST_STOP) && bit_end;
  assign tx_o    = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    if (state_q != ST_IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    case (state_q)
      ST_IDLE: if (start_i) begin
        state_d = ST_START;
        sh_d    = byte_i;
      end
      ST_START: if (bit_end) begin
        state_d = ST_DATA;
        bit_d   = 3'd0;
      end
      ST_DATA: if (bit_end) begin
        sh_d  = {1'b0, sh_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) state_d = ST_STOP;
      end
      ST_STOP: if (bit_end) begin
        // A start offered here chains the next byte with no idle bit in between.
        if (start_i) begin
          state_d = ST_START;
          sh_d    = byte_i;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_d = STOP_BIT;
    case (state_q)
      ST_START: tx_d = START_BIT;
      ST_DATA:  tx_d = sh_q[0];
      default:  tx_d = STOP_BIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_q    <= STOP_BIT;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

endmodule

// File: rtl/apu_reg_uart_tx.sv
// APU register-write UART encoder: two 8N1 frames (data, then address) per write.
// Optional request FIFO is enabled by defining APU_TX_FIFO_EN.
module apu_reg_uart_tx
  import apu_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  apu_reg_uart_tx_if.slave    wr,
  output logic                tx,
  output logic                busy
);

  apu_wr_t    in_w, src_w;
  logic       src_vld, pop;
  logic       byte_start, byte_idle, byte_done;
  logic [7:0] byte_mux, addr_byte_q;
  logic       sel_q, sel_d;

  assign in_w = '{index: wr.wr_index, data: wr.wr_data};

`ifdef APU_TX_FIFO_EN
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  apu_wr_t     mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, rp_q;
  logic        full, empty, push;

  // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
  assign empty      = (wp_q == rp_q);
  assign full       = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign src_vld    = !empty;
  assign src_w      = mem_q[rp_q[AW-1:0]];
  assign pop        = byte_idle && src_vld;
  assign wr.wr_ready = !full || pop;
  assign push       = wr.wr_valid && wr.wr_ready;
  assign busy       = !byte_idle || src_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + (AW+1)'(1);
      if (pop)  rp_q <= rp_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wp_q[AW-1:0]] <= in_w;
  end
`else
  assign src_vld     = wr.wr_valid;
  assign src_w       = in_w;
  assign pop         = byte_idle && src_vld;
  assign wr.wr_ready = byte_idle;
  assign busy        = !byte_idle;
`endif

  // sel_q=0 while the data byte is on the wire; its completion launches the address byte.
  assign byte_start = pop || (byte_done && !sel_q);
  assign byte_mux   = pop ? enc_data_byte(src_w) : addr_byte_q;

  always_comb begin
    sel_d = sel_q;
    if (pop)                     sel_d = 1'b0;
    else if (byte_done && !sel_q) sel_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_q <= 1'b1;
    else        sel_q <= sel_d;
  end

  always_ff @(posedge clk) begin
    if (pop) addr_byte_q <= enc_addr_byte(src_w);
  end

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (byte_start),
    .byte_i  (byte_mux),
    .idle_o  (byte_idle),
    .done_o  (byte_done),
    .tx_o    (tx)
  );

endmodule
